// File: rtl/aclk_disp_scan.sv
// Multiplexed BCD clock display scanner with an alarm FSM.
// Optional blanking of the display while ringing: define ACLK_DISP_BLINK_EN.
module aclk_disp_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] current_time,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic [4*NUM_DIGITS-1:0] key_time,
  input  logic                    show_new_time,
  input  logic                    show_a,
  input  logic                    alarm_en,
  input  logic                    stop_alarm,
  output logic [7:0]              disp_char,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    sound_alarm
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZED
  } alarm_st_t;

  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   frame;
  logic [DW-1:0]   src;
  logic [3:0]      digit;
  logic [NUM_DIGITS-1:0] sel;
  logic            tick;
  logic            idx_wrap;
  logic            match;
  alarm_st_t       state;
  alarm_st_t       state_nx;

  assign tick     = (cnt == CW'(REFRESH_DIV - 1));
  assign idx_wrap = (idx == IW'(NUM_DIGITS - 1));
  assign match    = (current_time == alarm_time);

  always_comb begin
    if (show_new_time)
      src = key_time;
    else if (show_a)
      src = alarm_time;
    else
      src = current_time;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= '0;
    end else if (tick) begin
      cnt <= '0;
      if (idx_wrap) begin
        idx   <= '0;
        frame <= src;
      end else begin
        idx <= idx + IW'(1);
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Outputs decode straight from idx/frame so reset reaches them at once
  assign digit     = frame[{idx, 2'b00} +: 4];
  assign disp_char = (digit > 4'd9) ? 8'h2D : (8'h30 + {4'd0, digit});
  assign sel       = NUM_DIGITS'(1) << idx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (alarm_en && match) state_nx = RINGING;
      RINGING: begin
        if (!alarm_en)
          state_nx = IDLE;
        else if (stop_alarm)
          state_nx = SNOOZED;
      end
      SNOOZED: if (!match || !alarm_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sound_alarm <= 1'b0;
    end else begin
      state       <= state_nx;
      sound_alarm <= (state_nx == RINGING);
    end
  end

`ifdef ACLK_DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV) + 1;

  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (!sound_alarm) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  assign digit_sel = (sound_alarm && phase) ? '0 : sel;
`else
  assign digit_sel = sel;
`endif

endmodule

// File: tb/tb_aclk_disp_scan.sv
// Randomized bench for aclk_disp_scan against a frame/alarm reference model.
module tb_aclk_disp_scan;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cur, alm, key;
  logic        snt, sa, aen, stp;
  logic [7:0]  disp_char;
  logic [3:0]  digit_sel;
  logic        sound_alarm;

  int checks = 0;
  int failures = 0;

  int          t;
  int          m_idx;
  int          m_st;
  int          rt;
  logic [15:0] m_frame;

  aclk_disp_scan #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(RD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .current_time (cur),
    .alarm_time   (alm),
    .key_time     (key),
    .show_new_time(snt),
    .show_a       (sa),
    .alarm_en     (aen),
    .stop_alarm   (stp),
    .disp_char    (disp_char),
    .digit_sel    (digit_sel),
    .sound_alarm  (sound_alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] d);
    return (d > 4'd9) ? 8'h2D : 8'h30 + {4'd0, d};
  endfunction

  task automatic model_reset();
    t = 0;
    m_idx = 0;
    m_st = 0;
    rt = 0;
    m_frame = '0;
  endtask

  task automatic model_step();
    bit match;
    bit tk;
    int prev;
    match = (cur == alm);
    t++;
    tk = (t % RD == 0);
    if (tk) begin
      m_idx = (t / RD) % N;
      if (m_idx == 0)
        m_frame = snt ? key : (sa ? alm : cur);
    end
    prev = m_st;
    case (m_st)
      0: if (aen && match) m_st = 1;
      1: if (!aen) m_st = 0; else if (stp) m_st = 2;
      2: if (!match || !aen) m_st = 0;
      default: m_st = 0;
    endcase
    if (tk && prev == 1) rt++;
    if (m_st != 1) rt = 0;
  endtask

  task automatic check_all();
    logic [3:0] exp_sel;
    exp_sel = 4'(1 << m_idx);
`ifdef ACLK_DISP_BLINK_EN
    if (m_st == 1 && ((rt / BD) % 2) == 1) exp_sel = 4'b0;
`endif
    check("char", disp_char, asc(m_frame[m_idx*4 +: 4]));
    check("sel", digit_sel, exp_sel);
    check("snd", sound_alarm, m_st == 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [15:0] rbcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  initial begin
    bit found;
    cur = 16'h1234;
    alm = 16'h0700;
    key = 16'h0000;
    snt = 0; sa = 0; aen = 0; stp = 0;
    model_reset();
    repeat (2) cyc();
    reset = 1'b1;
    repeat (40) cyc();
    // switch source mid-frame
    repeat (2) cyc();
    sa = 1; alm = 16'h5678;
    repeat (40) cyc();
    snt = 1; key = 16'h9A01;
    repeat (24) cyc();
    snt = 0; sa = 0;
    alm = 16'h0700; cur = 16'h0659; aen = 1;
    repeat (3) cyc();
    cur = 16'h0700;
    repeat (3) cyc();
    stp = 1;
    cyc();
    stp = 0;
    repeat (8) cyc();
    cur = 16'h0701;
    repeat (2) cyc();
    cur = 16'h0700;
    repeat (24) cyc();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_st == 1 && m_idx == 2) found = 1;
      else cyc();
    end
    check("ring_idx2", m_idx, 2);
    #2 reset = 1'b0;
    #1;
    check("rst_char", disp_char, 8'h30);
    check("rst_sel", digit_sel, 4'b0001);
    check("rst_snd", sound_alarm, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    alm = rbcd();
    for (int i = 0; i < 3000; i++) begin
      cyc();
      cur = ($urandom_range(3) == 0) ? alm : 16'($urandom);
      if ($urandom_range(19) == 0) alm = rbcd();
      key = 16'($urandom);
      if ($urandom_range(15) == 0) snt = 1'($urandom);
      if ($urandom_range(15) == 0) sa = 1'($urandom);
      aen = ($urandom_range(7) != 0);
      stp = ($urandom_range(5) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
